// File: rtl/sprite_palette_ram.sv
// Multi-bank sprite colour palette: {bank, index} -> 12-bit RGB with a two-cycle lookup.
// After reset an init sweep fills every entry with DEFAULT_RGB before writes are accepted.
module sprite_palette_ram #(
    parameter int unsigned INDEX_W = 4,
    parameter int unsigned BANK_W = 2,
    parameter int unsigned CH_W = 4,
    parameter logic [3*CH_W-1:0] DEFAULT_RGB = {4'hF, 4'hF, 4'hF},
    parameter logic [INDEX_W-1:0] TRANSPARENT_IDX = '0
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                pix_valid,
    input  logic [BANK_W-1:0]   pix_bank,
    input  logic [INDEX_W-1:0]  pix_index,
    output logic                out_valid,
    output logic [CH_W-1:0]     red,
    output logic [CH_W-1:0]     green,
    output logic [CH_W-1:0]     blue,
    output logic                out_transparent,
    input  logic                wr_en,
    input  logic [BANK_W-1:0]   wr_bank,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [3*CH_W-1:0]   wr_rgb,
    output logic                wr_ready,
    output logic                init_done
);

    localparam int unsigned ADDR_W = BANK_W + INDEX_W;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {StInit, StRun} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   sweep_q;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [3*CH_W-1:0]   mem_wdata;
    logic [3*CH_W-1:0]   mem [DEPTH];
    logic [3*CH_W-1:0]   rd_data_q;

    logic                s1_valid_q;
    logic [INDEX_W-1:0]  s1_index_q;
    logic                s1_init_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= StInit;
            sweep_q   <= '0;
            init_done <= 1'b0;
            wr_ready  <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    sweep_q <= sweep_q + 1'b1;
                    if (sweep_q == ADDR_W'(DEPTH - 1)) begin
                        state_q   <= StRun;
                        init_done <= 1'b1;
                        wr_ready  <= 1'b1;
                    end
                end
                StRun: begin
                    state_q <= StRun;
                end
                default: state_q <= StInit;
            endcase
        end
    end

    // The sweep owns the write port during init; external writes are simply dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = sweep_q;
        mem_wdata = DEFAULT_RGB;
        if (state_q == StInit) begin
            mem_we = 1'b1;
        end else if (wr_en && wr_ready) begin
            mem_we    = 1'b1;
            mem_waddr = {wr_bank, wr_index};
            mem_wdata = wr_rgb;
        end
    end

    // Read-first: the read samples the array before this edge's write lands.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rd_data_q <= mem[{pix_bank, pix_index}];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid_q <= 1'b0;
            s1_index_q <= '0;
            s1_init_q  <= 1'b0;
        end else begin
            s1_valid_q <= pix_valid;
            s1_index_q <= pix_index;
            s1_init_q  <= (state_q == StInit);
        end
    end

    // Lookups issued during init may hit entries the sweep has not reached yet.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid       <= 1'b0;
            out_transparent <= 1'b0;
            red             <= '0;
            green           <= '0;
            blue            <= '0;
        end else begin
            out_valid       <= s1_valid_q;
            out_transparent <= s1_valid_q && (s1_index_q == TRANSPARENT_IDX);
            if (s1_valid_q) begin
                {red, green, blue} <= s1_init_q ? DEFAULT_RGB : rd_data_q;
            end
        end
    end

endmodule
